// File: rtl/factor_verifier_if.sv
// factor_verifier_if: start/isDone handshake bundle between the controller and the factor verifier.
//   master modport : controller side (drives start, n, factor; observes results)
//   slave modport  : verifier side (samples request, drives busy/isDone/results)
//   start      request pulse
//   n          modulus (N_WIDTH)
//   factor     candidate factor p (F_WIDTH)
//   busy       division in progress
//   isDone     result valid level
//   quotient   n / p (N_WIDTH)
//   remainder  n % p (F_WIDTH)
//   isFactor   p is a non-trivial factor of n
//   error      p was zero
interface factor_verifier_if #(
  parameter int unsigned N_WIDTH = 64,
  parameter int unsigned F_WIDTH = 32
);
  logic               start;
  logic [N_WIDTH-1:0] n;
  logic [F_WIDTH-1:0] factor;
  logic               busy;
  logic               isDone;
  logic [N_WIDTH-1:0] quotient;
  logic [F_WIDTH-1:0] remainder;
  logic               isFactor;
  logic               error;

  modport master (
    output start, n, factor,
    input  busy, isDone, quotient, remainder, isFactor, error
  );

  modport slave (
    input  start, n, factor,
    output busy, isDone, quotient, remainder, isFactor, error
  );
endinterface

// File: rtl/factor_verifier.sv
// factor_verifier: checks a candidate factor p of modulus n by restoring, MSB-first
// bit-serial division. Reports quotient, remainder, non-trivial-factor flag and
// divide-by-zero error through the start/isDone handshake.
//   clk    rising-edge clock
//   reset  asynchronous, active-high reset
//   bus    factor_verifier_if.slave (start, n, factor in; busy, isDone, quotient,
//          remainder, isFactor, error out -- all outputs registered)
module factor_verifier #(
  parameter int unsigned N_WIDTH = 64,
  parameter int unsigned F_WIDTH = 32
) (
  input logic              clk,
  input logic              reset,
  factor_verifier_if.slave bus
);

  localparam int unsigned CNT_W = (N_WIDTH > 1) ? $clog2(N_WIDTH) : 1;
  localparam int unsigned R_W   = F_WIDTH + 1;

  // S_FAST is the one-cycle completion slot for p<2, so isDone rises one edge after acceptance
  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_DIVIDE = 2'd1,
    S_FAST   = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t r_state;
  state_t w_next_state;

  logic [N_WIDTH-1:0] r_n;
  logic [F_WIDTH-1:0] r_p;
  logic [R_W-1:0]     r_rem;
  logic [N_WIDTH-1:0] r_q;
  logic [CNT_W-1:0]   r_cnt;

  logic               r_busy;
  logic               r_done;
  logic [N_WIDTH-1:0] r_quotient;
  logic [F_WIDTH-1:0] r_remainder;
  logic               r_is_factor;
  logic               r_error;

  logic               w_accept;
  logic               w_go_divide;
  logic               w_step;
  logic               w_finish;
  logic               w_fast_finish;

  logic [R_W-1:0]     w_shift;
  logic [R_W-1:0]     w_sub;
  logic               w_ge;
  logic [R_W-1:0]     w_rem_next;
  logic [N_WIDTH-1:0] w_final_q;
  logic [F_WIDTH-1:0] w_final_r;
  logic               w_final_is_factor;

  // State register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // Next-state logic
  always_comb begin
    w_next_state = r_state;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        if (bus.start) begin
          w_next_state = (bus.factor > F_WIDTH'(1)) ? S_DIVIDE : S_FAST;
        end
      end
      S_DIVIDE: begin
        if (r_cnt == '0) begin
          w_next_state = S_DONE;
        end
      end
      S_FAST: begin
        w_next_state = S_DONE;
      end
      default: begin
        w_next_state = S_IDLE;
      end
    endcase
  end

  // Control strobes decoded from state; start is ignored outside IDLE/DONE
  always_comb begin
    w_accept      = 1'b0;
    w_go_divide   = 1'b0;
    w_step        = 1'b0;
    w_finish      = 1'b0;
    w_fast_finish = 1'b0;
    unique case (r_state)
      S_IDLE, S_DONE: begin
        w_accept    = bus.start;
        w_go_divide = bus.start && (bus.factor > F_WIDTH'(1));
      end
      S_DIVIDE: begin
        w_step   = 1'b1;
        w_finish = (r_cnt == '0);
      end
      S_FAST: begin
        w_fast_finish = 1'b1;
      end
      default: begin
        w_accept = 1'b0;
      end
    endcase
  end

  // One restoring-division step; r_n is shifted left so its MSB is always the current bit.
  // r_rem < p always fits in F_WIDTH bits, so the shifted value fits in F_WIDTH+1 bits.
  always_comb begin
    w_shift           = R_W'({r_rem, r_n[N_WIDTH-1]});
    w_sub             = w_shift - {1'b0, r_p};
    w_ge              = (w_shift >= {1'b0, r_p});
    w_rem_next        = w_ge ? w_sub : w_shift;
    w_final_q         = N_WIDTH'({r_q, w_ge});
    w_final_r         = F_WIDTH'(w_rem_next);
    w_final_is_factor = (w_final_r == '0) && (r_p > F_WIDTH'(1)) &&
                        (w_final_q > N_WIDTH'(1));
  end

  // Operand capture and iteration datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_n   <= '0;
      r_p   <= '0;
      r_rem <= '0;
      r_q   <= '0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_n   <= bus.n;
      r_p   <= bus.factor;
      r_rem <= '0;
      r_q   <= '0;
      r_cnt <= CNT_W'(N_WIDTH - 1);
    end else if (w_step) begin
      r_n   <= N_WIDTH'({r_n, 1'b0});
      r_q   <= w_final_q;
      r_rem <= w_rem_next;
      r_cnt <= r_cnt - CNT_W'(1);
    end
  end

  // Result and status registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b0;
      r_quotient  <= '0;
      r_remainder <= '0;
      r_is_factor <= 1'b0;
      r_error     <= 1'b0;
    end else if (w_accept) begin
      r_busy      <= w_go_divide;
      r_done      <= 1'b0;
      r_is_factor <= 1'b0;
      r_error     <= 1'b0;
    end else if (w_finish) begin
      r_busy      <= 1'b0;
      r_done      <= 1'b1;
      r_quotient  <= w_final_q;
      r_remainder <= w_final_r;
      r_is_factor <= w_final_is_factor;
    end else if (w_fast_finish) begin
      // Only p==0 or p==1 reach here
      r_done      <= 1'b1;
      r_remainder <= '0;
      r_is_factor <= 1'b0;
      if (r_p == '0) begin
        r_error    <= 1'b1;
        r_quotient <= '0;
      end else begin
        r_error    <= 1'b0;
        r_quotient <= r_n;
      end
    end
  end

  assign bus.busy      = r_busy;
  assign bus.isDone    = r_done;
  assign bus.quotient  = r_quotient;
  assign bus.remainder = r_remainder;
  assign bus.isFactor  = r_is_factor;
  assign bus.error     = r_error;

endmodule

// File: tb/tb_factor_verifier.sv
// tb_factor_verifier: table-driven, hand-sequenced and randomized checks of factor_verifier
// against an arithmetic reference model.
module tb_factor_verifier;

  localparam int unsigned NW = 64;
  localparam int unsigned FW = 32;
  localparam int unsigned DIV_LAT = NW;
  localparam int unsigned TIMEOUT = 200;

  logic clk;
  logic reset;

  int n_checks;
  int n_fails;

  factor_verifier_if #(.N_WIDTH(NW), .F_WIDTH(FW)) bus ();

  factor_verifier #(.N_WIDTH(NW), .F_WIDTH(FW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] n;
    logic [31:0] p;
    logic [63:0] q;
    logic [31:0] r;
    logic        isf;
    logic        err;
    int          lat;
  } vec_t;

  vec_t vecs[10];

  task automatic chk(input string name, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, got, exp, $time);
    end
  endtask

  // Reference: plain integer division and the factor definition
  task automatic model(input logic [63:0] n, input logic [31:0] p,
                       output logic [63:0] q, output logic [31:0] r,
                       output logic isf, output logic err, output int lat);
    logic [63:0] p64;
    p64 = {32'd0, p};
    err = (p == 32'd0);
    if (p == 32'd0) begin
      q = 64'd0;
      r = 32'd0;
    end else begin
      q = n / p64;
      r = 32'(n % p64);
    end
    isf = (p >= 32'd2) && (r == 32'd0) && (q >= 64'd2);
    lat = (p < 32'd2) ? 1 : int'(DIV_LAT);
  endtask

  // Wait for isDone, counting cycles from c0; returns the cycle count at which it rose
  task automatic wait_done(input int c0, output int lat);
    int c;
    c = c0;
    while (!bus.isDone && c < int'(TIMEOUT)) begin
      @(posedge clk);
      #1;
      c++;
    end
    lat = c;
  endtask

  // Present start for one edge (E0); returns #1 after E0
  task automatic pulse_start(input logic [63:0] n, input logic [31:0] p);
    bus.start  = 1'b1;
    bus.n      = n;
    bus.factor = p;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    bus.n      = $urandom;
    bus.factor = $urandom;
  endtask

  task automatic check_result(input string tag, input int lat, input vec_t v);
    chk({tag, "_latency"},   64'(lat),           64'(v.lat));
    chk({tag, "_quotient"},  bus.quotient,       v.q);
    chk({tag, "_remainder"}, 64'(bus.remainder), 64'(v.r));
    chk({tag, "_isFactor"},  64'(bus.isFactor),  64'(v.isf));
    chk({tag, "_error"},     64'(bus.error),     64'(v.err));
    chk({tag, "_busy_low"},  64'(bus.busy),      64'd0);
  endtask

  task automatic run_op(input string tag, input vec_t v);
    int lat;
    pulse_start(v.n, v.p);
    chk({tag, "_isDone_cleared"}, 64'(bus.isDone), 64'd0);
    chk({tag, "_busy_at_E0"}, 64'(bus.busy), 64'(v.p >= 32'd2));
    wait_done(0, lat);
    check_result(tag, lat, v);
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_busy"},      64'(bus.busy),      64'd0);
    chk({tag, "_isDone"},    64'(bus.isDone),    64'd0);
    chk({tag, "_quotient"},  bus.quotient,       64'd0);
    chk({tag, "_remainder"}, 64'(bus.remainder), 64'd0);
    chk({tag, "_isFactor"},  64'(bus.isFactor),  64'd0);
    chk({tag, "_error"},     64'(bus.error),     64'd0);
  endtask

  initial begin
    vec_t v;
    int   lat;
    logic [63:0] rn;
    logic [31:0] rp;

    n_checks = 0;
    n_fails  = 0;

    vecs[0] = '{n: 64'd15,  p: 32'd3,  q: 64'd5,  r: 32'd0,  isf: 1'b1, err: 1'b0, lat: 64};
    vecs[1] = '{n: 64'd143, p: 32'd12, q: 64'd11, r: 32'd11, isf: 1'b0, err: 1'b0, lat: 64};
    vecs[2] = '{n: 64'd143, p: 32'd13, q: 64'd11, r: 32'd0,  isf: 1'b1, err: 1'b0, lat: 64};
    vecs[3] = '{n: 64'hFFFF_FFFF_FFFF_FFFF, p: 32'hFFFF_FFFF, q: 64'h1_0000_0001,
                r: 32'd0, isf: 1'b1, err: 1'b0, lat: 64};
    vecs[4] = '{n: 64'd1234, p: 32'd0, q: 64'd0,    r: 32'd0, isf: 1'b0, err: 1'b1, lat: 1};
    vecs[5] = '{n: 64'd1234, p: 32'd1, q: 64'd1234, r: 32'd0, isf: 1'b0, err: 1'b0, lat: 1};
    vecs[6] = '{n: 64'd7,   p: 32'd7,   q: 64'd1, r: 32'd0,   isf: 1'b0, err: 1'b0, lat: 64};
    vecs[7] = '{n: 64'd100, p: 32'd200, q: 64'd0, r: 32'd100, isf: 1'b0, err: 1'b0, lat: 64};
    vecs[8] = '{n: 64'd4,   p: 32'd2,   q: 64'd2, r: 32'd0,   isf: 1'b1, err: 1'b0, lat: 64};
    vecs[9] = '{n: 64'h8000_0000_0000_0001, p: 32'd2, q: 64'h4000_0000_0000_0000,
                r: 32'd1, isf: 1'b0, err: 1'b0, lat: 64};

    reset      = 1'b1;
    bus.start  = 1'b0;
    bus.n      = '0;
    bus.factor = '0;
    repeat (3) @(posedge clk);
    #1;
    check_all_zero("reset");
    reset = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_isDone", 64'(bus.isDone), 64'd0);

    // Table-driven vectors, each started from the DONE state of the previous one
    for (int i = 0; i < 10; i++) begin
      run_op($sformatf("vec%0d", i), vecs[i]);
    end

    // Start pulsed at cycle 10 of a busy division must be ignored
    pulse_start(64'd143, 32'd13);
    repeat (9) @(posedge clk);
    #1;
    bus.start  = 1'b1;
    bus.n      = 64'd99;
    bus.factor = 32'd7;
    @(posedge clk);
    #1;
    bus.start  = 1'b0;
    chk("ignore_busy_held", 64'(bus.busy), 64'd1);
    wait_done(10, lat);
    check_result("ignore", lat, vecs[2]);

    // Reset at cycle 30 of a division clears everything immediately
    pulse_start(64'd15, 32'd3);
    repeat (29) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk);
    #1;
    check_all_zero("post_reset");
    v = '{n: 64'd15, p: 32'd5, q: 64'd3, r: 32'd0, isf: 1'b1, err: 1'b0, lat: 64};
    run_op("after_reset", v);

    // Randomized operations checked against the arithmetic model
    for (int k = 0; k < 24; k++) begin
      rn = {$urandom, $urandom};
      case ($urandom_range(0, 3))
        0: rp = 32'($urandom_range(0, 3));
        1: rp = 32'($urandom_range(2, 1000));
        2: rp = $urandom;
        default: begin
          rp = 32'($urandom_range(2, 65535));
          rn = {32'd0, rp} * {32'd0, $urandom};
        end
      endcase
      v.n = rn;
      v.p = rp;
      model(rn, rp, v.q, v.r, v.isf, v.err, v.lat);
      run_op($sformatf("rand%0d", k), v);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
